// File: rtl/pet_pkg.sv
// Shared constants, state encodings and stat arithmetic for the pet stat engine.
package pet_pkg;

    localparam logic [2:0] MAX_VAL         = 3'd5;
    localparam logic [2:0] FEED_INC        = 3'd2;
    localparam logic [2:0] PLAY_INC        = 3'd2;
    localparam logic [2:0] PLAY_SLEEP_COST = 3'd1;
    localparam logic [2:0] HEAL_INC        = 3'd1;

    typedef enum logic [2:0] {
        ALIVE    = 3'd0,
        SLEEPING = 3'd1,
        DEAD     = 3'd2
    } pet_state_e;

    // clamp(old + inc - dec, 0, MAX_VAL); operands stay small enough for a 4-bit signed sum
    function automatic logic [2:0] sat_add(input logic [2:0] old_val,
                                           input logic [2:0] inc,
                                           input logic [2:0] dec);
        logic signed [3:0] sum;
        sum = $signed({1'b0, old_val}) + $signed({1'b0, inc}) - $signed({1'b0, dec});
        if (sum < 4'sd0) begin
            return '0;
        end else if (sum > $signed({1'b0, MAX_VAL})) begin
            return MAX_VAL;
        end else begin
            return sum[2:0];
        end
    endfunction

    function automatic logic [2:0] stat_min3(input logic [2:0] a,
                                             input logic [2:0] b,
                                             input logic [2:0] c);
        logic [2:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

endpackage

// File: rtl/pet_stats_edge_pulse.sv
// Synchronous rising-edge detector: one-cycle pulse when the input goes from 0 to 1.
module edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic in_q;
    logic in_d;

    always_comb begin
        in_d = in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in_d;
        end
    end

    assign pulse = in & ~in_q;

endmodule

// File: rtl/pet_stats.sv
// Pet need stats: tick prescaler, per-stat decay counters, button actions and life-state machine.
module pet_stats
    import pet_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 50_000_000,
    parameter int unsigned FOOD_DECAY   = 10,
    parameter int unsigned SLEEP_DECAY  = 15,
    parameter int unsigned FUN_DECAY    = 8,
    parameter int unsigned HEALTH_DECAY = 5,
    parameter int unsigned SLEEP_GAIN   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_feed,
    input  logic       btn_play,
    input  logic       btn_sleep,
    input  logic       btn_heal,
    output logic [2:0] food,
    output logic [2:0] sleep,
    output logic [2:0] fun,
    output logic [2:0] happy,
    output logic [2:0] health,
    output logic [2:0] pet_state,
    output logic       tick
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW = 16;

    // Returns {request, next_count}; the request fires on the tick that completes a period.
    function automatic logic [CW:0] cnt_step(input logic [CW-1:0] cnt,
                                             input int unsigned   period,
                                             input logic          adv);
        if (!adv) begin
            return {1'b0, cnt};
        end
        if (cnt >= CW'(period - 1)) begin
            return {1'b1, {CW{1'b0}}};
        end
        return {1'b0, cnt + CW'(1)};
    endfunction

    logic feed_p, play_p, sleep_p, heal_p;

    edge_pulse u_edge_feed  (.clk(clk), .rst(rst), .in(btn_feed),  .pulse(feed_p));
    edge_pulse u_edge_play  (.clk(clk), .rst(rst), .in(btn_play),  .pulse(play_p));
    edge_pulse u_edge_sleep (.clk(clk), .rst(rst), .in(btn_sleep), .pulse(sleep_p));
    edge_pulse u_edge_heal  (.clk(clk), .rst(rst), .in(btn_heal),  .pulse(heal_p));

    logic [PW-1:0] pre_q, pre_d;
    logic          tick_q, tick_d;
    logic [CW-1:0] food_cnt_q, food_cnt_d;
    logic [CW-1:0] sleep_cnt_q, sleep_cnt_d;
    logic [CW-1:0] fun_cnt_q, fun_cnt_d;
    logic [CW-1:0] health_cnt_q, health_cnt_d;
    logic [CW-1:0] gain_cnt_q, gain_cnt_d;
    logic [2:0]    food_q, food_d;
    logic [2:0]    sleep_q, sleep_d;
    logic [2:0]    fun_q, fun_d;
    logic [2:0]    health_q, health_d;
    logic [2:0]    happy_q, happy_d;
    pet_state_e    state_q, state_d;

    logic active, awake, sleeping, any_zero;
    logic feed_act, play_act, heal_act;
    logic food_dec, sleep_dec, fun_dec, health_dec, gain_inc;
    logic [2:0] sleep_cost;

    always_comb begin
        pre_d  = (pre_q == PW'(TICK_DIV - 1)) ? '0 : pre_q + PW'(1);
        tick_d = (pre_q == PW'(TICK_DIV - 1));

        active   = (state_q != DEAD);
        awake    = (state_q == ALIVE);
        sleeping = (state_q == SLEEPING);
        any_zero = (food_q == '0) | (sleep_q == '0) | (fun_q == '0);

        feed_act = feed_p & awake;
        play_act = play_p & awake;
        heal_act = heal_p & active;

        {food_dec, food_cnt_d}     = cnt_step(food_cnt_q, FOOD_DECAY, tick_q & active);
        {fun_dec, fun_cnt_d}       = cnt_step(fun_cnt_q, FUN_DECAY, tick_q & active);
        {sleep_dec, sleep_cnt_d}   = cnt_step(sleep_cnt_q, SLEEP_DECAY, tick_q & awake);
        {health_dec, health_cnt_d} = cnt_step(health_cnt_q, HEALTH_DECAY,
                                              tick_q & active & any_zero);
        if (active && !any_zero) begin
            health_cnt_d = '0;
        end
        {gain_inc, gain_cnt_d} = cnt_step(gain_cnt_q, SLEEP_GAIN, tick_q & sleeping);
        if (awake && sleep_p) begin
            gain_cnt_d = '0;
        end

        // With the pet dead every inc/dec term is zero, so sat_add leaves stats unchanged.
        sleep_cost = (play_act ? PLAY_SLEEP_COST : 3'd0) + {2'b00, sleep_dec};
        food_d     = sat_add(food_q, feed_act ? FEED_INC : 3'd0, {2'b00, food_dec});
        fun_d      = sat_add(fun_q, play_act ? PLAY_INC : 3'd0, {2'b00, fun_dec});
        sleep_d    = sat_add(sleep_q, {2'b00, gain_inc}, sleep_cost);
        health_d   = sat_add(health_q, heal_act ? HEAL_INC : 3'd0, {2'b00, health_dec});

        state_d = state_q;
        case (state_q)
            ALIVE: begin
                if (health_q == '0) begin
                    state_d = DEAD;
                end else if (sleep_p) begin
                    state_d = SLEEPING;
                end
            end
            SLEEPING: begin
                if (health_q == '0) begin
                    state_d = DEAD;
                end else if (sleep_p || sleep_q == MAX_VAL) begin
                    state_d = ALIVE;
                end
            end
            DEAD:    state_d = DEAD;
            default: state_d = ALIVE;
        endcase

        happy_d = (state_d == DEAD) ? '0 : stat_min3(food_q, sleep_q, fun_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q        <= '0;
            tick_q       <= 1'b0;
            food_cnt_q   <= '0;
            sleep_cnt_q  <= '0;
            fun_cnt_q    <= '0;
            health_cnt_q <= '0;
            gain_cnt_q   <= '0;
            food_q       <= MAX_VAL;
            sleep_q      <= MAX_VAL;
            fun_q        <= MAX_VAL;
            health_q     <= MAX_VAL;
            happy_q      <= MAX_VAL;
            state_q      <= ALIVE;
        end else begin
            pre_q        <= pre_d;
            tick_q       <= tick_d;
            food_cnt_q   <= food_cnt_d;
            sleep_cnt_q  <= sleep_cnt_d;
            fun_cnt_q    <= fun_cnt_d;
            health_cnt_q <= health_cnt_d;
            gain_cnt_q   <= gain_cnt_d;
            food_q       <= food_d;
            sleep_q      <= sleep_d;
            fun_q        <= fun_d;
            health_q     <= health_d;
            happy_q      <= happy_d;
            state_q      <= state_d;
        end
    end

    assign food      = food_q;
    assign sleep     = sleep_q;
    assign fun       = fun_q;
    assign health    = health_q;
    assign happy     = happy_q;
    assign pet_state = state_q;
    assign tick      = tick_q;

endmodule

// File: tb/tb_pet_stats.sv
// Directed bench for pet_stats: expectations are queued per cycle and checked as the cycle arrives.
module tb_pet_stats;

    logic       clk;
    logic       rst;
    logic       btn_feed, btn_play, btn_sleep, btn_heal;
    logic [2:0] food, sleep, fun, happy, health, pet_state;
    logic       tick;

    pet_stats #(
        .TICK_DIV    (4),
        .FOOD_DECAY  (2),
        .SLEEP_DECAY (3),
        .FUN_DECAY   (2),
        .HEALTH_DECAY(1),
        .SLEEP_GAIN  (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_feed (btn_feed),
        .btn_play (btn_play),
        .btn_sleep(btn_sleep),
        .btn_heal (btn_heal),
        .food     (food),
        .sleep    (sleep),
        .fun      (fun),
        .happy    (happy),
        .health   (health),
        .pet_state(pet_state),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {S_FOOD, S_SLEEP, S_FUN, S_HAPPY, S_HEALTH, S_STATE, S_TICK} sig_e;

    typedef struct {
        int    cyc;
        string tag;
        sig_e  sel;
        int    val;
    } exp_t;

    localparam int B_FEED  = 0;
    localparam int B_PLAY  = 1;
    localparam int B_SLEEP = 2;
    localparam int B_HEAL  = 3;

    exp_t sb[$];
    int   cyc;
    int   n_asserts;
    int   n_fails;

    function automatic int observe(sig_e s);
        case (s)
            S_FOOD:   return int'(food);
            S_SLEEP:  return int'(sleep);
            S_FUN:    return int'(fun);
            S_HAPPY:  return int'(happy);
            S_HEALTH: return int'(health);
            S_STATE:  return int'(pet_state);
            default:  return int'(tick);
        endcase
    endfunction

    task automatic check_due();
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_asserts++;
            assert (observe(e.sel) === e.val) else begin
                n_fails++;
                $error("FAIL %s @cyc %0d: got %0d expected %0d", e.tag, cyc, observe(e.sel), e.val);
            end
        end
    endtask

    task automatic expect_at(input int at, input string tag, input sig_e sel, input int val);
        exp_t e;
        int   idx;
        e.cyc = at;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        idx = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > at) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, e);
        check_due();
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        check_due();
    endtask

    task automatic go_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            B_FEED:  btn_feed  = v;
            B_PLAY:  btn_play  = v;
            B_SLEEP: btn_sleep = v;
            default: btn_heal  = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        step();
        set_btn(b, 1'b0);
    endtask

    task automatic flush();
        n_asserts++;
        assert (sb.size() == 0) else begin
            n_fails++;
            $error("FAIL sb_pending: got %0d entries expected 0", sb.size());
        end
        sb.delete();
    endtask

    // One clock with rst high; cycle 0 is the negedge right after that edge.
    task automatic reset_dut();
        flush();
        btn_feed  = 1'b0;
        btn_play  = 1'b0;
        btn_sleep = 1'b0;
        btn_heal  = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic expect_fresh(input string pfx);
        expect_at(0, {pfx, "_food"},   S_FOOD,   5);
        expect_at(0, {pfx, "_sleep"},  S_SLEEP,  5);
        expect_at(0, {pfx, "_fun"},    S_FUN,    5);
        expect_at(0, {pfx, "_happy"},  S_HAPPY,  5);
        expect_at(0, {pfx, "_health"}, S_HEALTH, 5);
        expect_at(0, {pfx, "_state"},  S_STATE,  0);
        expect_at(0, {pfx, "_tick"},   S_TICK,   0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_asserts = 0;
        n_fails   = 0;
        cyc       = 0;
        rst       = 1'b1;
        btn_feed  = 1'b0;
        btn_play  = 1'b0;
        btn_sleep = 1'b0;
        btn_heal  = 1'b0;

        // Idle decay for two ticks, then a saturating feed.
        reset_dut();
        expect_fresh("rst");
        expect_at(9,  "idle_food",   S_FOOD,   4);
        expect_at(9,  "idle_fun",    S_FUN,    4);
        expect_at(9,  "idle_sleep",  S_SLEEP,  5);
        expect_at(9,  "idle_health", S_HEALTH, 5);
        expect_at(9,  "idle_state",  S_STATE,  0);
        expect_at(10, "idle_happy",  S_HAPPY,  4);
        expect_at(11, "feed_sat",    S_FOOD,   5);
        go_to(10);
        press(B_FEED);

        // Feed from food=1.
        reset_dut();
        expect_at(33, "feed_pre",   S_FOOD,  1);
        expect_at(35, "feed_plus2", S_FOOD,  3);
        expect_at(35, "feed_sleep", S_SLEEP, 3);
        go_to(34);
        press(B_FEED);

        // Feed from food=0 on the same tick as a food decrement.
        reset_dut();
        expect_at(41, "food_zero",       S_FOOD,   0);
        expect_at(48, "tick_coincide",   S_TICK,   1);
        expect_at(49, "feed_dec_food",   S_FOOD,   1);
        expect_at(49, "feed_dec_health", S_HEALTH, 3);
        go_to(48);
        press(B_FEED);

        // Play drives sleep to 0, health drains, pet dies and freezes.
        reset_dut();
        expect_at(17, "pre_sleep1", S_SLEEP,  1);
        expect_at(17, "pre_fun3",   S_FUN,    3);
        expect_at(19, "play_fun",   S_FUN,    5);
        expect_at(19, "play_sleep", S_SLEEP,  0);
        expect_at(21, "drain_h4",   S_HEALTH, 4);
        expect_at(25, "drain_h3",   S_HEALTH, 3);
        expect_at(29, "drain_h2",   S_HEALTH, 2);
        expect_at(33, "drain_h1",   S_HEALTH, 1);
        expect_at(37, "drain_h0",   S_HEALTH, 0);
        expect_at(37, "dying_state", S_STATE, 0);
        expect_at(38, "dead_state", S_STATE,  2);
        expect_at(38, "dead_happy", S_HAPPY,  0);
        expect_at(60, "frz_food",   S_FOOD,   1);
        expect_at(60, "frz_fun",    S_FUN,    3);
        expect_at(60, "frz_sleep",  S_SLEEP,  0);
        expect_at(60, "frz_health", S_HEALTH, 0);
        expect_at(60, "frz_state",  S_STATE,  2);
        expect_at(60, "frz_happy",  S_HAPPY,  0);
        press(B_PLAY);
        go_to(2);
        press(B_PLAY);
        go_to(4);
        press(B_PLAY);
        go_to(18);
        press(B_PLAY);
        go_to(39);
        press(B_FEED);
        go_to(41);
        press(B_PLAY);
        go_to(43);
        press(B_HEAL);
        go_to(45);
        press(B_SLEEP);
        go_to(60);

        // Reset out of DEAD; prescaler restarts so the first tick is 4 clocks later.
        reset_dut();
        expect_fresh("rdead");
        expect_at(1, "rdead_tick1", S_TICK, 0);
        expect_at(2, "rdead_tick2", S_TICK, 0);
        expect_at(3, "rdead_tick3", S_TICK, 0);
        expect_at(4, "rdead_tick4", S_TICK, 1);
        expect_at(5, "rdead_tick5", S_TICK, 0);
        go_to(5);

        // Sleep from sleep=2: feed ignored, +1 per tick, wake after reaching 5.
        reset_dut();
        expect_at(7,  "slp_enter",   S_STATE, 1);
        expect_at(7,  "slp_start",   S_SLEEP, 2);
        expect_at(9,  "slp_nofeed",  S_FOOD,  4);
        expect_at(9,  "slp_gain3",   S_SLEEP, 3);
        expect_at(13, "slp_gain4",   S_SLEEP, 4);
        expect_at(17, "slp_gain5",   S_SLEEP, 5);
        expect_at(17, "slp_still",   S_STATE, 1);
        expect_at(18, "slp_wake",    S_STATE, 0);
        press(B_PLAY);
        go_to(2);
        press(B_PLAY);
        go_to(4);
        press(B_PLAY);
        go_to(6);
        press(B_SLEEP);
        go_to(8);
        press(B_FEED);
        go_to(18);

        // Reset while SLEEPING with drained stats.
        reset_dut();
        expect_at(9, "pre_rslp_state", S_STATE, 1);
        press(B_PLAY);
        go_to(2);
        press(B_PLAY);
        go_to(4);
        press(B_PLAY);
        go_to(6);
        press(B_SLEEP);
        go_to(9);
        reset_dut();
        expect_fresh("rslp");

        // Heal held high for 20 clocks gives one increment only.
        reset_dut();
        expect_at(25, "hh_health3", S_HEALTH, 3);
        expect_at(25, "hh_sleep1",  S_SLEEP,  1);
        expect_at(25, "hh_state1",  S_STATE,  1);
        expect_at(25, "hh_fun4",    S_FUN,    4);
        expect_at(27, "hh_once",    S_HEALTH, 4);
        expect_at(41, "hh_food0",   S_FOOD,   0);
        expect_at(42, "hh_wake",    S_STATE,  0);
        expect_at(43, "hh_feed",    S_FOOD,   2);
        expect_at(46, "hh_hold",    S_HEALTH, 4);
        expect_at(47, "hh_release", S_HEALTH, 4);
        press(B_PLAY);
        go_to(2);
        press(B_PLAY);
        go_to(4);
        press(B_PLAY);
        go_to(18);
        press(B_PLAY);
        go_to(22);
        press(B_SLEEP);
        go_to(26);
        btn_heal = 1'b1;
        go_to(42);
        press(B_FEED);
        go_to(46);
        btn_heal = 1'b0;
        go_to(47);
        flush();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/pet_stats.md
Name: pet_stats

Overview:
- Stat engine of the Tamagotchi; sits directly upstream of the seven-segment display driver.
- Holds the pet's five 3-bit needs: food, sleep, fun, happy and health.
- Applies time-based decay and button-driven actions to those needs, and runs the pet life-state machine.
- Outputs connect straight to the display's foodValue/sleepValue/funValue/happyValue/healthValue/testValue inputs.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per game tick (1 s at 50 MHz); bench uses 4.
- FOOD_DECAY, 10, ticks between food decrements.
- SLEEP_DECAY, 15, ticks between sleep decrements while awake.
- FUN_DECAY, 8, ticks between fun decrements.
- HEALTH_DECAY, 5, ticks between health decrements while any need is 0.
- SLEEP_GAIN, 3, ticks between sleep increments while sleeping.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- btn_feed  in  1  debounced level; rising edge = feed.
- btn_play  in  1  debounced level; rising edge = play.
- btn_sleep  in  1  debounced level; rising edge = toggle sleep.
- btn_heal  in  1  debounced level; rising edge = medicine.
- food  out  3  0..5.
- sleep  out  3  0..5.
- fun  out  3  0..5.
- happy  out  3  0..5.
- health  out  3  0..5.
- pet_state  out  3  ALIVE=0, SLEEPING=1, DEAD=2; drives testValue.
- tick  out  1  one-cycle game-tick pulse, for debug.

Behaviour:
- Reset, sync on rst=1: food/sleep/fun/happy/health=5 (MAX_VAL); pet_state=ALIVE; all counters and edge registers=0; tick=0.
- Prescaler: counts 0..TICK_DIV-1. tick=1 for exactly the cycle in which the count wraps.
- Decay counters: one per stat (food, sleep, fun, health), clear on reset.
  - A counter advances only on tick.
  - When it reaches its period it clears to 0 and issues a one-cycle dec request.
- Button edges: pressed = btn & ~btn_q, where btn_q is the registered previous level. The action is visible on the outputs 1 clk after the sampled edge.
- Arithmetic:
  - Every stat update is new = clamp(old + inc - dec, 0, 5), using a 4-bit signed intermediate.
  - Simultaneous inc and dec in the same cycle both apply; no underflow or overflow wrap is permitted.
- ALIVE:
  - feed: food +2.
  - play: fun +2 and sleep -1.
  - heal: health +1.
  - sleep press: go to SLEEPING; SLEEP_GAIN counter clears.
  - Decay: food, sleep and fun decay normally.
  - Health decays only while food==0 | sleep==0 | fun==0. Its counter holds at 0 while all three are nonzero.
- SLEEPING:
  - feed and play are ignored; heal still applies.
  - The sleep decay counter is frozen.
  - sleep +1 every SLEEP_GAIN ticks.
  - Go to ALIVE on a sleep press, or automatically on the cycle after sleep reaches 5.
  - Food, fun and health decay continue.
- DEAD:
  - Entered on the clk after health==0 is registered, from either ALIVE or SLEEPING.
  - All stats and counters freeze; all buttons are ignored.
  - Exit only via rst.
- happy: registered min(food, sleep, fun); lags the stat registers by 1 clk. It is forced to 0 in DEAD.
- Reset mid-operation: rst overrides every pending action or decay in that cycle.
- The prescaler has no pause. A button edge arriving in the same cycle as tick is combined per the arithmetic rule.

Decomposition:
- Package pet_pkg holds:
  - MAX_VAL=5, FEED_INC=2, PLAY_INC=2, PLAY_SLEEP_COST=1, HEAL_INC=1;
  - the pet_state encodings ALIVE/SLEEPING/DEAD;
  - the saturating add function.
- Sub-module edge_pulse: sync rising-edge detector (clk, rst, in -> pulse), instantiated four times.
- Decay counters stay inline.

Test Plan:
All scenarios use TICK_DIV=4, FOOD_DECAY=2, SLEEP_DECAY=3, FUN_DECAY=2, HEALTH_DECAY=1, SLEEP_GAIN=1.
1. Reset, then idle 8 clk (2 ticks) -> food=4, fun=4, sleep=5, health=5, happy=4 one clk later; pet_state=0.
2. From food=1, pulse feed -> food=3 next clk. From food=4, feed -> food=5 (saturates). From food=0 with feed coincident with a food dec -> food=1.
3. Press play with sleep=1, fun=3 -> fun=5, sleep=0. Health then drops by 1 each tick until 0; pet_state=2 one clk later; happy=0. Further button presses change nothing.
4. With sleep=2, press sleep -> pet_state=1. Feed is ignored. sleep rises 3, 4, 5 on successive ticks, then pet_state=0 on the following clk.
5. Hold btn_heal high for 20 clk with health=3 -> exactly one increment, to 4 (edge-only).
6. Assert rst for 1 clk while SLEEPING or DEAD with stats partly drained -> all stats=5, pet_state=0, prescaler restarts (next tick exactly 4 clk after rst deasserts).
